// File: rtl/alu_result_display_if.sv
// rtl/alu_result_display_if.sv - ALU result handshake between the add/sub stage and the display block
interface alu_result_display_if #(
  parameter int N = 4
);
  logic [N:0] res;
  logic       cout;
  logic       overflow;
  logic       sub;
  logic       load;
  logic       busy;
  logic       done;

  modport master (output res, output cout, output overflow, output sub, output load,
                  input busy, input done);
  modport slave  (input res, input cout, input overflow, input sub, input load,
                  output busy, output done);
endinterface

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result latch, NZCV flags, double-dabble BCD and scanned 7-segment drive
// Optional: define ALU_DISPLAY_OVF_EN to show 'E' on the sign digit when the latched overflow flag is set.
module alu_result_display #(
  parameter int N        = 4,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_display_if.slave  bus,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic [6:0]           seg,
  output logic [DIGITS:0]      an
);
  localparam int CW = $clog2(N + 2);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 0) ? $clog2(DIGITS + 1) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [N:0]      mag_q, mag_d;
  logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;
  logic [BW-1:0]   disp_q, disp_d;
  logic            dsign_q, dsign_d, dovf_q, dovf_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N:0]      res_sext;
  logic            unused_res_msb;

  assign unused_res_msb = bus.res[N];
  assign res_sext       = {bus.res[N-1], bus.res[N-1:0]};

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fn_d    = fn_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    fv_d    = fv_q;
    disp_d  = disp_q;
    dsign_d = dsign_q;
    dovf_d  = dovf_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (!bus.sub)
            mag_d = {bus.cout, bus.res[N-1:0]};
          else if (bus.res[N-1])
            mag_d = ~res_sext + (N+1)'(1);
          else
            mag_d = {1'b0, bus.res[N-1:0]};
          fn_d    = bus.sub & bus.res[N-1];
          fz_d    = (bus.res[N-1:0] == '0);
          fc_d    = bus.cout;
          fv_d    = bus.overflow;
          bcd_d   = '0;
          cnt_d   = CW'(N + 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj[BW-2:0], mag_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        dsign_d = fn_q;
        dovf_d  = fv_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fn_q    <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fv_q    <= 1'b0;
      disp_q  <= '0;
      dsign_q <= 1'b0;
      dovf_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fn_q    <= fn_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      fv_q    <= fv_d;
      disp_q  <= disp_d;
      dsign_q <= dsign_d;
      dovf_q  <= dovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  // Leading-zero blanking: a digit shows once any digit at or above it is non-zero; digit 0 always shows.
  logic [DIGITS-1:0] show;
  logic              seen;
  logic [3:0]        cur_digit;
  logic              cur_show;

  always_comb begin
    seen = 1'b0;
    show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (disp_q[4*i +: 4] != 4'd0);
      show[i] = seen | (i == 0);
    end
    cur_digit = 4'd0;
    cur_show  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_show  = show[i];
      end
    end
  end

  always_comb begin
    an = ~((DIGITS+1)'(1) << idx_q);
    if (idx_q == IW'(DIGITS)) begin
`ifdef ALU_DISPLAY_OVF_EN
      seg = dovf_q ? 7'b0000110 : (dsign_q ? 7'b0111111 : 7'b1111111);
`else
      seg = dsign_q ? 7'b0111111 : 7'b1111111;
`endif
    end else begin
      seg = cur_show ? seg_enc(cur_digit) : 7'b1111111;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign flag_n   = fn_q;
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;
  assign flag_v   = fv_q;

endmodule

// File: tb/tb_alu_result_display.sv
// tb/tb_alu_result_display.sv - directed self-checking bench for alu_result_display (N=4, DIGITS=3, SCAN_DIV=4)
module tb_alu_result_display;
  logic       clk;
  logic       rst;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [6:0] seg;
  logic [3:0] an;
  int         n_cmp;
  int         n_fail;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;
`ifdef ALU_DISPLAY_OVF_EN
  localparam logic [6:0] OVF_SIGN = 7'h06;
`else
  localparam logic [6:0] OVF_SIGN = 7'h3F;
`endif

  alu_result_display_if #(.N(4)) bus ();

  alu_result_display #(.N(4), .DIGITS(3), .SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_v (flag_v),
    .seg    (seg),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [4:0] r, input logic c, input logic v, input logic s);
    @(negedge clk);
    bus.res = r; bus.cout = c; bus.overflow = v; bus.sub = s; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic read_digit(input int d, output logic [6:0] s, output bit ok);
    logic [3:0] target;
    target = ~(4'b0001 << d);
    ok = 1'b0;
    s  = 7'hxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an === target) begin s = seg; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.res = '0; bus.cout = 0; bus.overflow = 0; bus.sub = 0; bus.load = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, flag_n, flag_z, flag_c, flag_v} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 000000", {bus.busy, bus.done, flag_n, flag_z, flag_c, flag_v});
    end
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      n_fail++; $display("FAIL reset_disp: got an=%b seg=%h expected an=1110 seg=40", an, seg);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_18;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit ok;
    exp_seg = '{7'h00, 7'h79, BLANK, BLANK};
    do_load(5'b00010, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b expected 1", bus.busy); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL add_pre_done: got done=%b busy=%b expected done=0 busy=1", bus.done, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL add_done: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b expected 0", bus.done); end
    n_cmp++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0010) begin
      n_fail++; $display("FAIL add_flags: got %b expected 0010", {flag_n, flag_z, flag_c, flag_v});
    end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++; $display("FAIL add_seg%0d: got %h (found=%0d) expected %h", d, s, ok, exp_seg[d]);
      end
    end
  endtask

  task automatic test_sub_neg2;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit ok;
    exp_seg = '{7'h24, BLANK, BLANK, MINUS};
    do_load(5'b01110, 1'b0, 1'b0, 1'b1);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL neg2_done: got no done expected done pulse"); end
    n_cmp++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0) begin
      n_fail++; $display("FAIL neg2_flags: got n=%b z=%b expected n=1 z=0", flag_n, flag_z);
    end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++; $display("FAIL neg2_seg%0d: got %h (found=%0d) expected %h", d, s, ok, exp_seg[d]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit ok;
    exp_seg = '{7'h00, BLANK, BLANK, OVF_SIGN};
    do_load(5'b01000, 1'b0, 1'b1, 1'b1);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ovf_done: got no done expected done pulse"); end
    n_cmp++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1001) begin
      n_fail++; $display("FAIL ovf_flags: got %b expected 1001", {flag_n, flag_z, flag_c, flag_v});
    end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++; $display("FAIL ovf_seg%0d: got %h (found=%0d) expected %h", d, s, ok, exp_seg[d]);
      end
    end
  endtask

  task automatic test_zero_load_while_busy;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit ok;
    exp_seg = '{7'h40, BLANK, BLANK, BLANK};
    do_load(5'b00000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.res = 5'b00111; bus.sub = 1'b0; bus.load = 1'b1;
    repeat (4) @(negedge clk);
    bus.load = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL zero_ignored_load: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    n_cmp++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0100) begin
      n_fail++; $display("FAIL zero_flags: got %b expected 0100", {flag_n, flag_z, flag_c, flag_v});
    end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      n_cmp++;
      if (!ok || s !== exp_seg[d]) begin
        n_fail++; $display("FAIL zero_seg%0d: got %h (found=%0d) expected %h", d, s, ok, exp_seg[d]);
      end
    end
  endtask

  task automatic test_scan;
    logic [3:0] prev;
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      prev = an;
      @(negedge clk);
      if (an === 4'b1110 && prev !== 4'b1110) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL scan_sync: got an=%b expected entry to 1110", an); end
    for (int k = 0; k < 20; k++) begin
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      exp_s  = (((k / 4) % 4) == 0) ? 7'h40 : BLANK;
      n_cmp++;
      if (an !== exp_an || seg !== exp_s) begin
        n_fail++; $display("FAIL scan_k%0d: got an=%b seg=%h expected an=%b seg=%h", k, an, seg, exp_an, exp_s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_shift;
    int pulses;
    do_load(5'b00010, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, flag_n, flag_z, flag_c, flag_v} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_ctl: got %b expected 000000", {bus.busy, bus.done, flag_n, flag_z, flag_c, flag_v});
    end
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      n_fail++; $display("FAIL midrst_disp: got an=%b seg=%h expected an=1110 seg=40", an, seg);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d busy/done cycles expected 0", pulses); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_add_18();
    test_sub_neg2();
    test_overflow();
    test_zero_load_while_busy();
    test_scan();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
